// File: rtl/rf_write_scheduler_pkg.sv
// rf_pkg: shared sizes and FSM encoding for the register file write scheduler
package rf_pkg;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int NUM_REGS = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, COMMIT = 2'd2} state_t;
endpackage

// File: rtl/rf_write_scheduler_if.sv
// rf_write_scheduler_if: packed valid/ready write-request bundle from NUM_REQ requesters
interface rf_write_scheduler_if #(
  parameter int NUM_REQ = rf_pkg::NUM_REQ,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int DATA_W = rf_pkg::DATA_W
);
  logic [NUM_REQ-1:0] valid;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] data;
  modport master(output valid, addr, data, input ready);
  modport slave(input valid, addr, data, output ready);
endinterface

// File: rtl/rf_write_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last+1 with wrap
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [NUM_REQ-1:0] grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IW = $clog2(NUM_REQ);
  // walk farthest to nearest so the nearest valid requester overwrites the rest
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req[(int'(last) + k) % NUM_REQ]) begin
        grant = '0;
        grant[(int'(last) + k) % NUM_REQ] = 1'b1;
        idx = IW'((int'(last) + k) % NUM_REQ);
      end
  end
endmodule

// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler: round-robin owner of the register file write port with RAW hazard flag
// RF_ZERO_REG_EN: register 0 is hardwired zero, so writes to it are accepted and dropped
module rf_write_scheduler #(
  parameter int NUM_REQ = rf_pkg::NUM_REQ,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int DATA_W = rf_pkg::DATA_W
) (
  input  logic clk,
  input  logic reset,
  rf_write_scheduler_if.slave req,
  output logic rf_regwrite,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic rd_hazard,
  output logic busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  import rf_pkg::*;
  localparam int IW = $clog2(NUM_REQ);
  state_t state;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0] win, last_grant;
  logic [ADDR_W-1:0] hold_addr, win_addr;
  logic [DATA_W-1:0] hold_data, win_data;
  logic pend_valid, acc, zero_w;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req.valid),
    .last(last_grant),
    .grant(gnt),
    .idx(win)
  );
  assign req.ready = (state == IDLE && reset) ? gnt : '0;
  assign acc = |req.ready;
  assign win_addr = req.addr[win*ADDR_W +: ADDR_W];
  assign win_data = req.data[win*DATA_W +: DATA_W];
`ifdef RF_ZERO_REG_EN
  assign zero_w = win_addr == '0;
`else
  assign zero_w = 1'b0;
`endif
  assign rf_write_reg = hold_addr;
  assign rf_write_data = hold_data;
  assign rd_hazard = pend_valid & ((rd_addr1 == hold_addr) | (rd_addr2 == hold_addr));
  assign busy = state != IDLE;
  // hold registers only change on a real accepted write, so the write bus never glitches
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      hold_addr <= '0;
      hold_data <= '0;
      pend_valid <= 1'b0;
      last_grant <= IW'(NUM_REQ - 1);
      grant_id <= '0;
      rf_regwrite <= 1'b0;
    end else
      case (state)
        IDLE:
          if (acc) begin
            last_grant <= win;
            grant_id <= win;
            if (!zero_w) begin
              hold_addr <= win_addr;
              hold_data <= win_data;
              pend_valid <= 1'b1;
              rf_regwrite <= 1'b1;
              state <= ISSUE;
            end
          end
        ISSUE: begin
          rf_regwrite <= 1'b0;
          state <= COMMIT;
        end
        COMMIT: begin
          pend_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Shares the single write port of the 8x8-bit signed register file among NUM_REQ requesters, using round-robin arbitration with a valid/ready handshake.
- Sequences the register file's one-cycle-delayed write-enable pipeline: RegWrite is asserted in one cycle, and address/data are held through the commit cycle.
- Tracks the in-flight write and flags read-after-write hazards to the reader.
- Sits between the execute/writeback requesters and the register file.

Parameters:
- NUM_REQ, 3, number of write requesters.
- ADDR_W, 3, register address width.
- DATA_W, 8, write data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
- req_addr  in  NUM_REQ*ADDR_W  packed destination addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed write data, same packing.
- rf_regwrite  out  1  register file write enable.
- rf_write_reg  out  ADDR_W  register file write address.
- rf_write_data  out  DATA_W  register file write data.
- rd_addr1  in  ADDR_W  reader source address 1.
- rd_addr2  in  ADDR_W  reader source address 2.
- rd_hazard  out  1  a source address matches the pending write.
- busy  out  1  FSM not in IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rf_regwrite=0; rf_write_reg=0; rf_write_data=0.
  - pend_valid=0; last_grant=NUM_REQ-1; grant_id=0.
  - req_ready=0, rd_hazard=0, busy=0.
  - Asserting reset mid-sequence abandons the write. The top level drives the register file's active-high reset from the inverted reset, so the file clears alongside this block.
- FSM states: IDLE -> ISSUE -> COMMIT -> IDLE. Fixed 3-cycle sequence, so peak throughput is one write per 3 cycles.
- IDLE:
  - Round-robin search starts at last_grant+1 and wraps modulo NUM_REQ.
  - Combinational req_ready is one-hot on the first valid requester.
  - On the clock edge with valid&ready: capture addr/data into hold registers, set pend_valid=1, last_grant=grant_id=winner, go to ISSUE.
  - No valid requests: stay in IDLE, req_ready=0.
- ISSUE:
  - rf_regwrite=1; rf_write_reg and rf_write_data driven from hold registers.
  - req_ready=0; go to COMMIT.
- COMMIT:
  - rf_regwrite=0; rf_write_reg and rf_write_data held stable. The register file commits the write at the end of this cycle.
  - At that edge: pend_valid=0, go to IDLE.
- Outside ISSUE/COMMIT, rf_write_reg and rf_write_data keep their last values (no glitching to 0).
- Requesters must hold valid, addr and data stable until ready. Deasserting valid before acceptance is allowed; the request is simply not taken.
- Requests arriving in ISSUE/COMMIT wait; they are considered in the next IDLE cycle.
- rd_hazard (combinational) = pend_valid & ((rd_addr1==hold_addr) | (rd_addr2==hold_addr)).
  - Covers the ISSUE and COMMIT cycles, the first being the accept edge.
  - A read in the cycle after COMMIT sees the new value, given the register file's registered read address.
- busy = (state != IDLE).

Optional Feature:
- Macro: RF_ZERO_REG_EN.
- Defined: register 0 is hardwired zero.
  - Requests with addr==0 are still accepted via the normal handshake.
  - For such requests: FSM returns IDLE->IDLE in one cycle, rf_regwrite stays 0, pend_valid stays 0.
  - rd_hazard is never raised for address 0.
- Undefined: register 0 is an ordinary register; all addresses take the 3-cycle sequence.

Decomposition:
- Package rf_pkg holds:
  - ADDR_W=3, DATA_W=8, NUM_REGS=8;
  - the state encoding IDLE=2'd0, ISSUE=2'd1, COMMIT=2'd2 as a typedef.
- One sub-module, rr_arbiter:
  - inputs: request vector, last_grant;
  - outputs: one-hot grant and encoded index;
  - purely combinational, reused by other shared-port blocks.

Test Plan:
- Single write: after reset, req_valid=3'b001, addr=5, data=8'h7F. Required:
  - req_ready[0] in the same cycle;
  - rf_regwrite=1 on the next cycle with write_reg=5, write_data=8'h7F;
  - addr/data held one more cycle;
  - a register-file read of 5 in the following cycle returns 8'h7F.
- Round-robin fairness: all three requesters valid continuously. Required:
  - grant order 0,1,2,0,1,2, one grant every 3 cycles;
  - no requester starved.
- Hazard: rd_addr1=5 while the write to 5 is in flight. Required:
  - rd_hazard=1 from the accept edge through COMMIT;
  - rd_hazard=0 in the cycle after COMMIT;
  - rd_addr2=4 alone never raises it.
- Reset mid-operation: pull reset low during ISSUE. Required:
  - rf_regwrite=0 immediately;
  - busy=0, rd_hazard=0;
  - after release, the next grant goes to requester 0.
- Negative data: write 8'h80 to register 3, read back. Required: 8'h80, i.e. -128, preserved bit-exact.
- RF_ZERO_REG_EN: write 8'h55 to register 0. Required:
  - accepted in one cycle, rf_regwrite never asserted, rd_hazard=0;
  - without the macro, the normal 3-cycle write occurs.
